rf_frame_tx: RTL

Pulse-position-modulated frame transmitter; the sending end of the RF sync link whose receiver locks on preamble/sync runs and raises `sh_en`. It serializes one frame (guard, 8-bit preamble, 27-bit payload A, 8-bit sync, 32-bit payload B) onto `rfout`. Each bit occupies one fixed-length slot: a `1` produces a short pulse at a fixed offset within the slot; a `0` leaves the line low. It sits between the digital payload source and the RF driver, mirroring the frame format the receiver expects.

---
 rtl/rf_frame_pkg.sv | 47 ++++
 rtl/rf_frame_tx_pulse_slot.sv | 43 ++++
 rtl/rf_frame_tx.sv | 138 +++++++++++++
 3 files changed

// File: rtl/rf_frame_pkg.sv
// Shared types and frame-layout constants for the PPM frame transmitter.
// Field lengths and field sequencing live here so the FSM and bench agree.
package rf_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GUARD,
    ST_PRE,
    ST_PAY_A,
    ST_SYNC,
    ST_PAY_B,
    ST_PARITY,
    ST_DONE
  } rf_tx_state_t;

  localparam int GUARD_LEN = 2;
  localparam int PRE_LEN   = 8;
  localparam int PAY_A_LEN = 27;
  localparam int SYNC_LEN  = 8;
  localparam int PAY_B_LEN = 32;

  // Number of slots in the field a state transmits.
  function automatic logic [5:0] field_len(rf_tx_state_t s);
    case (s)
      ST_GUARD: field_len = 6'(GUARD_LEN);
      ST_PRE:   field_len = 6'(PRE_LEN);
      ST_PAY_A: field_len = 6'(PAY_A_LEN);
      ST_SYNC:  field_len = 6'(SYNC_LEN);
      ST_PAY_B: field_len = 6'(PAY_B_LEN);
      default:  field_len = 6'd1;
    endcase
  endfunction

  // Field that follows s once its last slot ends.
  function automatic rf_tx_state_t next_field(rf_tx_state_t s,
                                              logic par_en);
    case (s)
      ST_GUARD: next_field = ST_PRE;
      ST_PRE:   next_field = ST_PAY_A;
      ST_PAY_A: next_field = ST_SYNC;
      ST_SYNC:  next_field = ST_PAY_B;
      ST_PAY_B: next_field = par_en ? ST_PARITY : ST_DONE;
      default:  next_field = ST_DONE;
    endcase
  endfunction

endpackage

// File: rtl/rf_frame_tx_pulse_slot.sv
// Slot timer and registered PPM pulse output.
// bit_val is the slot bit that applies on the cycle after the edge.
module rf_pulse_slot #(
  parameter int BIT_PERIOD  = 10000,
  parameter int PULSE_POS   = 100,
  parameter int PULSE_WIDTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic bit_val,
  output logic slot_end,
  output logic rfout
);

  localparam int CW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_PERIOD - 1);

  logic [CW-1:0] cyc;
  logic [CW-1:0] cyc_nxt;
  logic          hit;

  // Next slot position and pulse-window test on it, so the flop lines up
  // with cyc and a pulse never spills past the slot boundary.
  always_comb begin
    slot_end = run && (cyc == LAST);
    cyc_nxt  = (run && !slot_end) ? cyc + CW'(1) : '0;
    hit      = (int'(cyc_nxt) >= PULSE_POS) &&
               (int'(cyc_nxt) < PULSE_POS + PULSE_WIDTH);
  end

  // Slot counter and output flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc   <= '0;
      rfout <= 1'b0;
    end else begin
      cyc   <= cyc_nxt;
      rfout <= bit_val && hit;
    end
  end

endmodule

// File: rtl/rf_frame_tx.sv
// PPM frame transmitter: guard, preamble, payload A, sync, payload B.
// Define RF_TX_PARITY_EN to append an even-parity slot after payload B.
module rf_frame_tx
  import rf_frame_pkg::*;
#(
  parameter int BIT_PERIOD  = 10000,
  parameter int PULSE_POS   = 100,
  parameter int PULSE_WIDTH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_start,
  input  logic [26:0] tx_payload_a,
  input  logic [31:0] tx_payload_b,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        rfout
);

`ifdef RF_TX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  rf_tx_state_t state;
  rf_tx_state_t nxt_st;
  logic [5:0]   bit_cnt;
  logic [26:0]  sr_a;
  logic [31:0]  sr_b;
  logic         par;
  logic         run;
  logic         slot_end;
  logic         last;
  logic         cur_bit;
  logic         head_bit;
  logic         bit_val;

`ifdef RF_TX_PARITY_EN
  logic par_q;
  // Even parity of both payloads, captured with the start.
  always_ff @(posedge clk) begin
    if (rst) par_q <= 1'b0;
    else if (state == ST_IDLE && tx_start)
      par_q <= ^{tx_payload_a, tx_payload_b};
  end
  assign par = par_q;
`else
  assign par = 1'b0;
`endif

  // Current slot bit, and the bit for the cycle after this edge.
  always_comb begin
    run    = (state != ST_IDLE) && (state != ST_DONE);
    nxt_st = next_field(state, PAR_EN);
    last   = bit_cnt == field_len(state) - 6'd1;
    case (state)
      ST_PRE, ST_SYNC: cur_bit = 1'b1;
      ST_PAY_A:        cur_bit = sr_a[26];
      ST_PAY_B:        cur_bit = sr_b[31];
      ST_PARITY:       cur_bit = par;
      default:         cur_bit = 1'b0;
    endcase
    case (nxt_st)
      ST_PRE, ST_SYNC: head_bit = 1'b1;
      ST_PAY_A:        head_bit = sr_a[26];
      ST_PAY_B:        head_bit = sr_b[31];
      ST_PARITY:       head_bit = par;
      default:         head_bit = 1'b0;
    endcase
    if (!slot_end)
      bit_val = cur_bit;
    else if (last)
      bit_val = head_bit;
    else if (state == ST_PAY_A)
      bit_val = sr_a[25];
    else if (state == ST_PAY_B)
      bit_val = sr_b[30];
    else
      bit_val = cur_bit;
  end

  // Frame sequencer: start capture, field stepping, busy/done flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      sr_a    <= '0;
      sr_b    <= '0;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx_start) begin
            sr_a    <= tx_payload_a;
            sr_b    <= tx_payload_b;
            bit_cnt <= '0;
            tx_busy <= 1'b1;
            state   <= ST_GUARD;
          end
        end
        ST_DONE: begin
          tx_busy <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          if (slot_end) begin
            if (state == ST_PAY_A) sr_a <= {sr_a[25:0], 1'b0};
            if (state == ST_PAY_B) sr_b <= {sr_b[30:0], 1'b0};
            if (last) begin
              bit_cnt <= '0;
              state   <= nxt_st;
              tx_done <= (nxt_st == ST_DONE);
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
        end
      endcase
    end
  end

  rf_pulse_slot #(
    .BIT_PERIOD (BIT_PERIOD),
    .PULSE_POS  (PULSE_POS),
    .PULSE_WIDTH(PULSE_WIDTH)
  ) u_slot (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .bit_val (bit_val),
    .slot_end(slot_end),
    .rfout   (rfout)
  );

endmodule
